gpio_bidir_seq: RTL and testbench
=================================

# gpio_bidir_seq

Transaction sequencer for an 8-bit half-duplex parallel link to an external device. It sits on the fabric side of the bidirectional GPIO pad buffer. It turns single-word write/read requests into pad-level activity:
- tristate control and data toward the buffer;
- separate write and read strobes;
- bus-turnaround gaps.

For reads it captures the registered pad data back from the buffer and returns it as a one-cycle response.

## Interface
Parameters:
- STROBE_CYCLES, 2, width of wr_strobe/rd_strobe pulses in cycles; legal 1..255
- TURNAROUND, 2, released-bus cycles inserted after every write; legal 0..255 (0 = none)
- SAMPLE_DELAY, 1, cycles after rd_strobe deasserts before din_i is sampled; covers the buffer's input register; legal 1..255

Ports:
- clk  input  1  single clock for all logic
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_write  input  1  1 = write, 0 = read; sampled with req_data on acceptance
- req_data  input  8  write data
- rsp_valid  output  1  one-cycle pulse, read data valid
- rsp_data  output  8  captured read data; held until the next read completes
- dout_o  output  8  data to pad buffer I input
- oe_n_o  output  1  pad buffer T input: 1 = released/input, 0 = driving
- din_i  input  8  registered pad data from the buffer
- wr_strobe_o  output  1  write strobe to device
- rd_strobe_o  output  1  read strobe to device

## Operation
- The request is accepted on a rising edge with req_valid && req_ready.
- req_write and req_data are latched on acceptance. The latched copy is used for the whole transaction; later input changes are ignored.
- States and transitions:
  - IDLE: req_ready=1, bus released. On accept, go to WR_SETUP (write) or RD_STROBE (read).
  - WR_SETUP: 1 cycle. oe_n_o=0, dout_o=data, strobe low.
  - WR_STROBE: STROBE_CYCLES cycles. Data still driven, wr_strobe_o=1.
  - WR_HOLD: 1 cycle. Data driven, strobe low.
  - TURN: TURNAROUND cycles. oe_n_o=1. If TURNAROUND=0, go WR_HOLD -> IDLE directly.
  - RD_STROBE: STROBE_CYCLES cycles. oe_n_o=1, rd_strobe_o=1.
  - RD_WAIT: SAMPLE_DELAY cycles, strobe low. On the edge ending the last RD_WAIT cycle, din_i is captured into rsp_data.
  - RD_DONE: 1 cycle. rsp_valid=1, then IDLE.
- The block never drives (oe_n_o=0) outside WR_SETUP/WR_STROBE/WR_HOLD.
- wr_strobe_o and rd_strobe_o are never high together, and neither is high in the same cycle as a direction change.
- dout_o keeps the last written value when released; its value is don't-care while oe_n_o=1.
- Cycle counter:
  - 8 bits; loads on state entry and counts down to the state's last cycle.
  - No wrap; parameter values outside the legal range are unsupported.
- There is no back-pressure on rsp_valid. The consumer must take it when it pulses.

## Timing
- All outputs are registered, functions of state only. There are no combinational paths from inputs to outputs.
- Reset values: req_ready=0 while rst_n=0, then 1 from the first cycle after release. oe_n_o=1, dout_o=0, wr_strobe_o=0, rd_strobe_o=0, rsp_valid=0, rsp_data=0.
- Write: req_ready is low for 2+STROBE_CYCLES+TURNAROUND cycles after acceptance. oe_n_o falls in the cycle after acceptance.
- Read: rsp_valid rises STROBE_CYCLES+SAMPLE_DELAY+1 cycles after acceptance. req_ready is low for STROBE_CYCLES+SAMPLE_DELAY+1 cycles.
- Back-to-back requests have at least 1 IDLE cycle between transactions, because req_ready is high only in IDLE.
- Reset mid-transaction:
  - Asynchronous assertion releases the bus (oe_n_o=1) and drops strobes immediately.
  - The transaction is discarded with no rsp_valid.
  - FSM resumes in IDLE.
- req_valid asserted during reset is ignored. It is accepted on the first IDLE edge after release if still high.

## Test plan
- Reset release, then idle: oe_n_o=1, strobes 0, rsp_valid 0, req_ready=1 one cycle after rst_n rises.
- Write 0xA5 (defaults): accept at edge E0. Expected over the next 6 cycles:
  - oe_n_o=0 with dout_o=0xA5 for 4 cycles;
  - wr_strobe_o=1 in cycles 2-3 only;
  - oe_n_o=1 in cycles 5-6;
  - req_ready=1 in cycle 7.
- Read with din_i=0x3C (defaults): rd_strobe_o=1 in cycles 1-2 after acceptance, oe_n_o stays 1, then rsp_valid=1 with rsp_data=0x3C in cycle 4.
- Write 0x11 then read with req_valid held high: exactly 1 IDLE cycle before rd_strobe_o rises; oe_n_o=1 for TURNAROUND cycles before it; no overlap of strobes or driving.
- Assert rst_n=0 during WR_STROBE: oe_n_o=1 and wr_strobe_o=0 asynchronously; after release, a read returns correct data with no stale rsp_valid.
- TURNAROUND=0, STROBE_CYCLES=1, SAMPLE_DELAY=3:
  - write busy for exactly 3 cycles;
  - read rsp_valid at cycle 5;
  - din_i changed after the sample edge does not alter rsp_data.

Source files
------------

// File: rtl/gpio_bidir_seq.sv
// Half-duplex 8-bit link sequencer for the fabric side of a GPIO pad buffer.
// Turns single-word requests into strobed pad transactions with bus turnaround.
module gpio_bidir_seq #(
   parameter int unsigned STROBE_CYCLES = 2,
   parameter int unsigned TURNAROUND    = 2,
   parameter int unsigned SAMPLE_DELAY  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic [7:0] dout_o,
   output logic       oe_n_o,
   input  logic [7:0] din_i,
   output logic       wr_strobe_o,
   output logic       rd_strobe_o
);

   localparam logic [7:0] SC_M1 = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] SD_M1 = 8'(SAMPLE_DELAY - 1);
   localparam logic [7:0] TA_M1 =
      (TURNAROUND == 0) ? 8'd0 : 8'(TURNAROUND - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_SETUP,
      WR_STROBE,
      WR_HOLD,
      TURN,
      RD_STROBE,
      RD_WAIT,
      RD_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       ready_q, ready_d;
   logic       oe_n_q, oe_n_d;
   logic       wr_q, wr_d;
   logic       rd_q, rd_d;
   logic       rv_q, rv_d;
   logic [7:0] dout_q, dout_d;
   logic [7:0] rdata_q, rdata_d;
   logic       accept;

   assign accept = req_valid && ready_q;

   // Counter loads N-1 on entry; a state ends on the cycle it reads zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = req_write ? WR_SETUP : RD_STROBE;
               cnt_d   = req_write ? 8'd0 : SC_M1;
            end
         end
         WR_SETUP: begin
            state_d = WR_STROBE;
            cnt_d   = SC_M1;
         end
         WR_STROBE: begin
            if (cnt_q == 8'd0) state_d = WR_HOLD;
            else               cnt_d   = cnt_q - 8'd1;
         end
         WR_HOLD: begin
            state_d = (TURNAROUND == 0) ? IDLE : TURN;
            cnt_d   = TA_M1;
         end
         TURN: begin
            if (cnt_q == 8'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         RD_STROBE: begin
            if (cnt_q == 8'd0) begin
               state_d = RD_WAIT;
               cnt_d   = SD_M1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RD_WAIT: begin
            if (cnt_q == 8'd0) state_d = RD_DONE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         RD_DONE: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track state exactly.
   always_comb begin
      ready_d = (state_d == IDLE);
      oe_n_d  = !((state_d == WR_SETUP) ||
                  (state_d == WR_STROBE) ||
                  (state_d == WR_HOLD));
      wr_d    = (state_d == WR_STROBE);
      rd_d    = (state_d == RD_STROBE);
      rv_d    = (state_d == RD_DONE);
      dout_d  = (accept && req_write) ? req_data : dout_q;
      rdata_d = ((state_q == RD_WAIT) && (cnt_q == 8'd0)) ? din_i : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         ready_q <= 1'b0;
         oe_n_q  <= 1'b1;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rv_q    <= 1'b0;
         dout_q  <= 8'd0;
         rdata_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         oe_n_q  <= oe_n_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rv_q    <= rv_d;
         dout_q  <= dout_d;
         rdata_q <= rdata_d;
      end
   end

   assign req_ready   = ready_q;
   assign oe_n_o      = oe_n_q;
   assign wr_strobe_o = wr_q;
   assign rd_strobe_o = rd_q;
   assign rsp_valid   = rv_q;
   assign dout_o      = dout_q;
   assign rsp_data    = rdata_q;

endmodule

// File: tb/tb_gpio_bidir_seq.sv
// Bench for gpio_bidir_seq: default instance and a short-timing instance.
// Vector table plus scoreboard for read data, and hand sequences for corners.
module tb_gpio_bidir_seq;

   logic       clk;
   logic       rst_n;
   logic       a_valid, b_valid;
   logic       req_write;
   logic [7:0] req_data;
   logic [7:0] din;

   logic       a_ready, a_rv, a_oe_n, a_wr, a_rd;
   logic [7:0] a_rdata, a_dout;
   logic       b_ready, b_rv, b_oe_n, b_wr, b_rd;
   logic [7:0] b_rdata, b_dout;

   gpio_bidir_seq u_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_valid), .req_ready(a_ready),
      .req_write(req_write), .req_data(req_data),
      .rsp_valid(a_rv), .rsp_data(a_rdata),
      .dout_o(a_dout), .oe_n_o(a_oe_n), .din_i(din),
      .wr_strobe_o(a_wr), .rd_strobe_o(a_rd)
   );

   gpio_bidir_seq #(
      .STROBE_CYCLES(1), .TURNAROUND(0), .SAMPLE_DELAY(3)
   ) u_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_valid), .req_ready(b_ready),
      .req_write(req_write), .req_data(req_data),
      .rsp_valid(b_rv), .rsp_data(b_rdata),
      .dout_o(b_dout), .oe_n_o(b_oe_n), .din_i(din),
      .wr_strobe_o(b_wr), .rd_strobe_o(b_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ready, oe_n, wr, rd, rv;
      logic [7:0] rdata, dout;
   } outs_t;

   typedef struct {
      int         inst;
      logic       wr;
      logic [7:0] data;
      logic [7:0] din;
      int         busy;
      int         rspc;
   } vec_t;

   outs_t      a_o, b_o;
   vec_t       tv[8];
   logic [7:0] sb[$];
   int         nvec;
   int         nerr;

   always_comb begin
      a_o = '{a_ready, a_oe_n, a_wr, a_rd, a_rv, a_rdata, a_dout};
      b_o = '{b_ready, b_oe_n, b_wr, b_rd, b_rv, b_rdata, b_dout};
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic sb_pop(input logic [7:0] act);
      logic [7:0] exp;
      if (sb.size() == 0) begin
         nvec++;
         nerr++;
         $display("FAIL stale_rsp: got rsp %0h expected none", act);
      end else begin
         exp = sb.pop_front();
         chk("rsp_data", 32'(act), 32'(exp));
      end
   endtask

   task automatic set_valid(input int inst, input logic v);
      if (inst == 0) a_valid = v;
      else           b_valid = v;
   endtask

   task automatic run_vec(input vec_t v);
      int    sc, sd;
      outs_t o;
      sc = (v.inst == 0) ? 2 : 1;
      sd = (v.inst == 0) ? 1 : 3;
      o  = (v.inst == 0) ? a_o : b_o;
      chk("pre_ready", 32'(o.ready), 32'd1);
      req_write = v.wr;
      req_data  = v.data;
      din       = v.din;
      set_valid(v.inst, 1'b1);
      if (!v.wr) sb.push_back(v.din);
      @(negedge clk);
      set_valid(v.inst, 1'b0);
      req_write = ~v.wr;
      req_data  = ~v.data;
      for (int k = 1; k <= v.busy + 1; k++) begin
         o = (v.inst == 0) ? a_o : b_o;
         if (v.wr) begin
            chk("wr_oe_n", 32'(o.oe_n), 32'(k > 2 + sc));
            chk("wr_strobe", 32'(o.wr), 32'((k >= 2) && (k <= 1 + sc)));
            chk("wr_rd_quiet", 32'(o.rd), 32'd0);
            if (k <= 2 + sc) chk("wr_dout", 32'(o.dout), 32'(v.data));
            chk("wr_rv", 32'(o.rv), 32'd0);
         end else begin
            chk("rd_oe_n", 32'(o.oe_n), 32'd1);
            chk("rd_wr_quiet", 32'(o.wr), 32'd0);
            chk("rd_strobe", 32'(o.rd), 32'(k <= sc));
            chk("rd_rv", 32'(o.rv), 32'(k == v.rspc));
            if (k == v.busy + 1)
               chk("rd_held", 32'(o.rdata), 32'(v.din));
         end
         chk("ready", 32'(o.ready), 32'(k > v.busy));
         if (o.rv) sb_pop(o.rdata);
         if (!v.wr && (k == sc + sd + 1)) din = ~v.din;
         if (k <= v.busy) @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      outs_t o;
      nvec      = 0;
      nerr      = 0;
      rst_n     = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      req_write = 1'b0;
      req_data  = 8'h00;
      din       = 8'h00;

      tv[0] = '{0, 1'b1, 8'hA5, 8'h00, 6, 0};
      tv[1] = '{0, 1'b0, 8'h00, 8'h3C, 4, 4};
      tv[2] = '{0, 1'b1, 8'hFF, 8'h00, 6, 0};
      tv[3] = '{0, 1'b0, 8'h00, 8'h5A, 4, 4};
      tv[4] = '{1, 1'b1, 8'h00, 8'h00, 3, 0};
      tv[5] = '{1, 1'b0, 8'h00, 8'hC3, 5, 5};
      tv[6] = '{1, 1'b1, 8'h7E, 8'h00, 3, 0};
      tv[7] = '{1, 1'b0, 8'h00, 8'h81, 5, 5};

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(a_ready), 32'd0);
      chk("rst_oe_n", 32'(a_oe_n), 32'd1);
      chk("rst_wr", 32'(a_wr), 32'd0);
      chk("rst_rd", 32'(a_rd), 32'd0);
      chk("rst_rv", 32'(a_rv), 32'd0);
      chk("rst_b_ready", 32'(b_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(a_ready), 32'd1);
      chk("rel_b_ready", 32'(b_ready), 32'd1);
      chk("rel_oe_n", 32'(a_oe_n), 32'd1);
      chk("rel_dout", 32'(a_dout), 32'd0);
      chk("rel_rdata", 32'(a_rdata), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(tv[i]);

      // Reset in the middle of a write strobe
      req_write = 1'b1;
      req_data  = 8'h66;
      a_valid   = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      chk("mid_wr_strobe", 32'(a_wr), 32'd1);
      chk("mid_oe_n", 32'(a_oe_n), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_oe_n", 32'(a_oe_n), 32'd1);
      chk("async_wr", 32'(a_wr), 32'd0);
      chk("async_ready", 32'(a_ready), 32'd0);
      chk("async_rdata", 32'(a_rdata), 32'd0);
      chk("async_dout", 32'(a_dout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_rv", 32'(a_rv), 32'd0);
      @(negedge clk);
      chk("post_rst_ready", 32'(a_ready), 32'd1);
      run_vec('{0, 1'b0, 8'h00, 8'h96, 4, 4});

      // Write then read with valid held: one idle cycle in between
      req_write = 1'b1;
      req_data  = 8'h11;
      a_valid   = 1'b1;
      @(negedge clk);
      req_write = 1'b0;
      req_data  = 8'h00;
      din       = 8'h99;
      sb.push_back(8'h99);
      for (int k = 1; k <= 12; k++) begin
         o = a_o;
         chk("b2b_oe_n", 32'(o.oe_n), 32'(k > 4));
         chk("b2b_wr", 32'(o.wr), 32'((k == 2) || (k == 3)));
         chk("b2b_rd", 32'(o.rd), 32'((k == 8) || (k == 9)));
         chk("b2b_overlap", 32'(o.wr & o.rd), 32'd0);
         chk("b2b_ready", 32'(o.ready), 32'((k == 7) || (k == 12)));
         chk("b2b_rv", 32'(o.rv), 32'(k == 11));
         if (k <= 4) chk("b2b_dout", 32'(o.dout), 32'h11);
         if (o.rv) sb_pop(o.rdata);
         if (k == 8) a_valid = 1'b0;
         if (k < 12) @(negedge clk);
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
